rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (we/waddr/wdata) between NUM_REQ writeback sources
//  (0=ALU pipe, 1=mult/div unit, 2=load/store unit) using round-robin arbitration.
//  Tracks in-flight destinations in a 32-entry pending scoreboard so decode can stall on RAW hazards.
//  Sits between the writeback sources and the 32x32 register file; drives the file's write port exclusively.
// PARAMETERS
//  NUM_REQ  3   number of writeback requesters (2..8)
//  DATA_W   32  register data width
//  ADDR_W   5   register address width (2**ADDR_W registers)
// PORTS
//  clk         in   1               clock, all state on rising edge
//  reset       in   1               asynchronous, active-high
//  req_valid   in   NUM_REQ         requester i has a write pending
//  req_addr    in   NUM_REQ*ADDR_W  destination of requester i, slice [i*ADDR_W +: ADDR_W]
//  req_data    in   NUM_REQ*DATA_W  write data of requester i, slice [i*DATA_W +: DATA_W]
//  req_ready   out  NUM_REQ         one-hot grant; handshake completes when valid&ready
//  rf_we       out  1               register-file write enable (registered)
//  rf_waddr    out  ADDR_W          register-file write address (registered)
//  rf_wdata    out  DATA_W          register-file write data (registered)
//  issue_valid in   1               decode issues an instruction that writes issue_addr
//  issue_addr  in   ADDR_W          destination register being marked pending
//  rs_addr     in   ADDR_W          decode source operand 1
//  rt_addr     in   ADDR_W          decode source operand 2
//  rs_busy     out  1               rs_addr has an outstanding write
//  rt_busy     out  1               rt_addr has an outstanding write
// BEHAVIOUR
//  - Reset (async): rf_we=0, rf_waddr=0, rf_wdata=0, rr pointer=0, all pending bits=0; req_ready=0
//    while reset high. Reset mid-transfer drops the in-flight write; no rf_we after release.
//  - Arbitration: combinational; among asserted req_valid, grant the first index >= ptr, wrapping
//    modulo NUM_REQ. At most one req_ready high per cycle; req_ready[i] never high without req_valid[i].
//  - Pointer: on a completed handshake by index g, ptr <= (g+1) mod NUM_REQ; unchanged with no grant.
//  - Requesters hold valid/addr/data stable until ready; deasserting valid before ready is legal (no write).
//  - Latency: handshake at edge N -> rf_we/rf_waddr/rf_wdata valid in cycle N+1; the file captures at edge N+1.
//    No handshake -> rf_we=0 next cycle; rf_waddr/rf_wdata hold their previous values.
//  - Register 0: handshake to addr 0 completes normally (ready high) but rf_we stays 0 for it.
//  - Throughput: one write per cycle, back-to-back; no bubbles between grants.
//  - Scoreboard: pending[r] set at the edge where issue_valid && issue_addr==r && r!=0.
//    pending[r] cleared at the edge where rf_we && rf_waddr==r (same edge the file writes).
//    Set and clear on the same r in the same cycle: set wins (newer producer outstanding).
//    Issue to r=0 ignored; pending[0] is constant 0.
//  - rs_busy = pending[rs_addr]; rt_busy = pending[rt_addr]. Combinational from state, no bypass;
//    busy drops the cycle after the file holds the new value.
//  - Re-issue to an already pending r keeps it pending; the first matching writeback clears it
//    (single-bit scoreboard). Decode must not issue a second producer to a pending r.
//  - Scoreboard is independent of arbitration order; writebacks may complete out of issue order.
// STRUCTURE
//  - Shared package rf_ctrl_pkg: REG_ZERO constant, ADDR_W/DATA_W defaults, requester index
//    constants REQ_ALU=0, REQ_MDU=1, REQ_LSU=2.
//  - Sub-module rr_arbiter (NUM_REQ): req vector + ptr in, one-hot grant + encoded index out; pure
//    combinational. Pointer register, write-port register and scoreboard stay in rf_wb_arbiter.
// TESTING
//  1 Reset: assert reset mid-run with req_valid=3'b111 -> rf_we=0, req_ready=0, rs_busy=rt_busy=0 immediately.
//  2 Round-robin: all three valid, addrs 5/6/7, data A/B/C, held -> grants 0,1,2,0...; rf_waddr 5,6,7 on
//    consecutive cycles, each one cycle after its grant.
//  3 Zero reg: req0 addr 0 data 32'hDEADBEEF -> req_ready[0]=1, rf_we stays 0; ptr advances to 1.
//  4 Scoreboard: issue r9; next cycle rs_addr=9 -> rs_busy=1; MDU writes r9 ->
//    rs_busy=0 the cycle after rf_we with rf_waddr=9.
//  5 Set-vs-clear: issue r12 in same cycle as rf_we to r12 -> pending[12] remains 1 (rt_busy=1 for rt_addr=12).
//  6 Starvation: req0 continuously valid, req2 asserts once -> req2 granted within NUM_REQ cycles.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared constants for the register-file write path: default widths,
// the hardwired zero register and fixed writeback requester indices.
package rf_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_ZERO   = 0;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MDU = 1;
  localparam int unsigned REQ_LSU = 2;

  // Round-robin successor of a granted index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo NUM_REQ; one-hot grant plus encoded index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int unsigned cand;

  // Scan NUM_REQ positions starting at ptr; first asserted request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any && req[cand[IDX_W-1:0]]) begin
        grant_any                 = 1'b1;
        grant[cand[IDX_W-1:0]]    = 1'b1;
        grant_idx                 = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among writeback sources (round-robin)
// and keeps a pending-write scoreboard so decode can stall on RAW hazards.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic [ADDR_W-1:0]         rt_addr,
  output logic                      rs_busy,
  output logic                      rt_busy
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [IDX_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  req_live;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // No grants are offered while reset is held.
  assign req_live = reset ? '0 : req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_live),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // One-hot AND-OR select of the winning requester's payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= IDX_W'(rr_next(32'(grant_idx), NUM_REQ));
    end
  end

  // Write port register; a handshake to the zero register completes without a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant_any && (sel_addr != ADDR_W'(REG_ZERO));
      if (grant_any) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  // Clear on the writing edge, then set so a new producer overrides the retiring one.
  always_comb begin
    pending_nxt = pending;
    if (rf_we) begin
      pending_nxt[rf_waddr] = 1'b0;
    end
    if (issue_valid && (issue_addr != ADDR_W'(REG_ZERO))) begin
      pending_nxt[issue_addr] = 1'b1;
    end
    pending_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign rs_busy = pending[rs_addr];
  assign rt_busy = pending[rt_addr];

endmodule
